// File: rtl/gpio_pkg.sv
// Shared GPIO definitions.
//
// Holds the port width and default debounce depth that the GPIO port and the
// upper-level peripherals reuse, plus the per-bit debounce decision used by
// gpio_debounce_bit.
//
// Contents:
//   GPIO_WIDTH            - number of GPIO bits in port 0
//   GPIO_DB_COUNT_DEFAULT - consecutive differing sample ticks to accept a level
//   GPIO_CNT_W_DEFAULT    - debounce counter width
//   db_action_e           - what a debounce bit does on a given clock
//   db_decide()           - maps (tick, differs, at_limit) to a db_action_e
package gpio_pkg;

  localparam int GPIO_WIDTH            = 16;
  localparam int GPIO_DB_COUNT_DEFAULT = 4;
  localparam int GPIO_CNT_W_DEFAULT    = 8;

  // Action taken by one debounce bit on the current clock.
  typedef enum logic [1:0] {
    DB_HOLD    = 2'd0,  // no sample tick: counter and stable level hold
    DB_RESTART = 2'd1,  // synced level matches stable level: drop any partial count
    DB_ADVANCE = 2'd2,  // differs, not yet long enough: count one more tick
    DB_ACCEPT  = 2'd3   // differs for DB_COUNT ticks: take the new level
  } db_action_e;

  function automatic db_action_e db_decide(input logic tick,
                                           input logic differs,
                                           input logic at_limit);
    db_action_e act;
    act = DB_HOLD;
    if (tick) begin
      if (!differs)     act = DB_RESTART;
      else if (at_limit) act = DB_ACCEPT;
      else              act = DB_ADVANCE;
    end
    return act;
  endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// One GPIO bit: two-flop synchronizer, tick-paced debounce counter, stable
// (clean) level register and registered rise/fall pulses.
//
// Ports:
//   clk         - core clock, rising edge
//   rst         - synchronous active-high reset
//   pin         - raw asynchronous pin level
//   sample_tick - one-cycle debounce strobe from the prescaler
//   clean       - debounced level
//   edge_rise   - one-cycle pulse when clean goes 0->1
//   edge_fall   - one-cycle pulse when clean goes 1->0
module gpio_debounce_bit
  import gpio_pkg::*;
#(
  parameter int DB_COUNT = GPIO_DB_COUNT_DEFAULT,  // legal range 1..255
  parameter int CNT_W    = GPIO_CNT_W_DEFAULT     // 2**CNT_W must exceed DB_COUNT
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  input  logic sample_tick,
  output logic clean,
  output logic edge_rise,
  output logic edge_fall
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DB_COUNT - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  db_action_e       action;

  // NOTE: combinational blocks use blocking '=', and every output gets a value
  // on every path so no latch is inferred.
  always_comb begin
    action = db_decide(sample_tick, sync2 != clean, cnt >= LIMIT);
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples the
  // pre-edge value of the others (sync1 -> sync2 shifts by exactly one clock).
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the counter is cleared by reset too, so a count interrupted by
      // reset never carries partial credit into the next acceptance.
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      cnt       <= '0;
      clean     <= 1'b0;
      edge_rise <= 1'b0;
      edge_fall <= 1'b0;
    end else begin
      sync1     <= pin;
      sync2     <= sync1;
      edge_rise <= 1'b0;
      edge_fall <= 1'b0;
      case (action)
        DB_RESTART: cnt <= '0;
        DB_ADVANCE: cnt <= cnt + CNT_W'(1);
        DB_ACCEPT: begin
          clean     <= sync2;
          cnt       <= '0;
          // clean only changes here, and only to the opposite level, so at
          // most one of the two pulses can be high.
          edge_rise <= sync2;
          edge_fall <= ~sync2;
        end
        default: ;  // DB_HOLD: counter and stable level keep their values
      endcase
    end
  end

endmodule

// File: rtl/gpio_in_conditioner.sv
// Input conditioning for GPIO port 0.
//
// Synchronizes and debounces WIDTH raw pins (one gpio_debounce_bit per bit),
// producing the clean word read as GPIO_0_in, per-bit edge pulses, and a
// sticky, maskable interrupt status with a single OR-reduced interrupt line.
//
// Ports:
//   clk         - core clock, rising edge
//   rst         - synchronous active-high reset
//   pin_in      - raw asynchronous pin levels
//   sample_tick - one-cycle debounce strobe from the prescaler
//   rise_en     - per-bit rising-edge interrupt enable
//   fall_en     - per-bit falling-edge interrupt enable
//   irq_clr_we  - status clear strobe
//   irq_clr     - write-1-to-clear mask, qualified by irq_clr_we
//   gpio_clean  - debounced level
//   edge_rise   - one-cycle pulse per bit on clean 0->1
//   edge_fall   - one-cycle pulse per bit on clean 1->0
//   irq_status  - sticky interrupt flags
//   irq         - OR of irq_status
module gpio_in_conditioner
  import gpio_pkg::*;
#(
  parameter int WIDTH    = GPIO_WIDTH,
  parameter int DB_COUNT = GPIO_DB_COUNT_DEFAULT,
  parameter int CNT_W    = GPIO_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin_in,
  input  logic             sample_tick,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic             irq_clr_we,
  input  logic [WIDTH-1:0] irq_clr,
  output logic [WIDTH-1:0] gpio_clean,
  output logic [WIDTH-1:0] edge_rise,
  output logic [WIDTH-1:0] edge_fall,
  output logic [WIDTH-1:0] irq_status,
  output logic             irq
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_debounce_bit #(
      .DB_COUNT (DB_COUNT),
      .CNT_W    (CNT_W)
    ) u_db (
      .clk         (clk),
      .rst         (rst),
      .pin         (pin_in[i]),
      .sample_tick (sample_tick),
      .clean       (gpio_clean[i]),
      .edge_rise   (edge_rise[i]),
      .edge_fall   (edge_fall[i])
    );
  end

  logic [WIDTH-1:0] set_mask;
  logic [WIDTH-1:0] clr_mask;

  // Enables are applied to the registered pulses, so an enable only matters
  // in the cycle its edge pulse is high; toggling it alone changes nothing.
  always_comb begin
    set_mask = (edge_rise & rise_en) | (edge_fall & fall_en);
    clr_mask = irq_clr_we ? irq_clr : '0;
  end

  // Clear first, then OR in the set: a bit set and cleared together stays set.
  always_ff @(posedge clk) begin
    if (rst) irq_status <= '0;
    else     irq_status <= (irq_status & ~clr_mask) | set_mask;
  end

  // Driven only from flops, so the interrupt line does not glitch.
  assign irq = |irq_status;

endmodule

// File: tb/tb_gpio_in_conditioner.sv
module tb_gpio_in_conditioner;

  localparam int W  = 16;
  localparam int DB = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] pin_in;
  logic         sample_tick;
  logic [W-1:0] rise_en;
  logic [W-1:0] fall_en;
  logic         irq_clr_we;
  logic [W-1:0] irq_clr;
  logic [W-1:0] gpio_clean;
  logic [W-1:0] edge_rise;
  logic [W-1:0] edge_fall;
  logic [W-1:0] irq_status;
  logic         irq;

  int n_cmp = 0;
  int n_bad = 0;

  gpio_in_conditioner #(.WIDTH(W), .DB_COUNT(DB), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .pin_in      (pin_in),
    .sample_tick (sample_tick),
    .rise_en     (rise_en),
    .fall_en     (fall_en),
    .irq_clr_we  (irq_clr_we),
    .irq_clr     (irq_clr),
    .gpio_clean  (gpio_clean),
    .edge_rise   (edge_rise),
    .edge_fall   (edge_fall),
    .irq_status  (irq_status),
    .irq         (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pins reach the debouncer two clocks late; each bit keeps
  // a run length of consecutive ticks on which the delayed pin disagrees with
  // the accepted level, and accepts the new level when the run reaches DB.
  logic [W-1:0] m_d1, m_d2, m_clean, m_rise, m_fall, m_status;
  int           m_run [W];

  initial begin
    m_d1 = '0; m_d2 = '0; m_clean = '0; m_rise = '0; m_fall = '0; m_status = '0;
    for (int i = 0; i < W; i++) m_run[i] = 0;
  end

  always @(posedge clk) begin
    logic [W-1:0] nr, nf;
    if (rst) begin
      m_d1 = '0; m_d2 = '0; m_clean = '0; m_rise = '0; m_fall = '0; m_status = '0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
    end else begin
      m_status = (m_status & ~(irq_clr_we ? irq_clr : '0))
               | (m_rise & rise_en) | (m_fall & fall_en);
      nr = '0;
      nf = '0;
      if (sample_tick) begin
        for (int i = 0; i < W; i++) begin
          if (m_d2[i] != m_clean[i]) begin
            m_run[i] = m_run[i] + 1;
            if (m_run[i] == DB) begin
              m_clean[i] = m_d2[i];
              m_run[i]   = 0;
              if (m_d2[i]) nr[i] = 1'b1;
              else         nf[i] = 1'b1;
            end
          end else begin
            m_run[i] = 0;
          end
        end
      end
      m_rise = nr;
      m_fall = nf;
      m_d2   = m_d1;
      m_d1   = pin_in;
    end
  end

  // Advance n clocks; returns 1 ns after the last rising edge.
  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic settle();
    rise_en = '0; fall_en = '0; pin_in = '0; sample_tick = 1'b1;
    irq_clr_we = 1'b0; irq_clr = '0;
    cyc(12);
    irq_clr_we = 1'b1; irq_clr = '1;
    cyc(1);
    irq_clr_we = 1'b0; irq_clr = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; pin_in = 16'hFFFF; sample_tick = 1'b1;
    rise_en = '0; fall_en = '0; irq_clr_we = 1'b0; irq_clr = '0;
    cyc(3);
    n_cmp++;
    if ({gpio_clean, edge_rise, edge_fall, irq_status, irq} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: clean=%h rise=%h fall=%h status=%h irq=%b, required all 0",
               gpio_clean, edge_rise, edge_fall, irq_status, irq);
    end
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      cyc(1);
      if (k < 6) begin
        n_cmp++;
        if (gpio_clean !== 16'h0000 || edge_rise !== 16'h0000) begin
          n_bad++;
          $display("FAIL reset_release_early edge %0d: clean=%h rise=%h, required 0000/0000",
                   k, gpio_clean, edge_rise);
        end
      end else begin
        n_cmp++;
        if (gpio_clean !== 16'hFFFF || edge_rise !== 16'hFFFF) begin
          n_bad++;
          $display("FAIL reset_release_accept: clean=%h rise=%h, required FFFF/FFFF",
                   gpio_clean, edge_rise);
        end
      end
    end
    cyc(1);
    n_cmp++;
    if (edge_rise !== 16'h0000 || gpio_clean !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL reset_release_pulse_width: clean=%h rise=%h, required FFFF/0000",
               gpio_clean, edge_rise);
    end
  endtask

  task automatic test_glitch();
    int pulses;
    settle();
    pulses = 0;
    pin_in = 16'h0008;
    for (int k = 0; k < 12; k++) begin
      if (k == 3) pin_in = 16'h0000;
      cyc(1);
      if (edge_rise[3]) pulses++;
    end
    n_cmp++;
    if (gpio_clean[3] !== 1'b0 || pulses != 0) begin
      n_bad++;
      $display("FAIL glitch_3_ticks: clean3=%b pulses=%0d, required 0/0", gpio_clean[3], pulses);
    end
    pin_in = 16'h0008;
    for (int k = 0; k < 12; k++) begin
      if (k == 4) pin_in = 16'h0000;
      cyc(1);
      if (edge_rise[3]) pulses++;
      if (k == 5) begin
        n_cmp++;
        if (gpio_clean[3] !== 1'b1) begin
          n_bad++;
          $display("FAIL glitch_4_ticks_accept: clean3=%b, required 1", gpio_clean[3]);
        end
      end
    end
    n_cmp++;
    if (pulses != 1) begin
      n_bad++;
      $display("FAIL glitch_4_ticks_pulses: pulses=%0d, required 1", pulses);
    end
  endtask

  task automatic test_prescaled();
    int ticks, rose_at, pulses;
    settle();
    ticks = 0; rose_at = -1; pulses = 0;
    pin_in = 16'h0001;
    for (int c = 0; c < 48; c++) begin
      sample_tick = (c % 8 == 7);
      cyc(1);
      if (sample_tick) ticks++;
      if (edge_rise[0]) pulses++;
      if (gpio_clean[0] && rose_at < 0) rose_at = ticks;
    end
    sample_tick = 1'b1;
    n_cmp++;
    if (rose_at != 4 || pulses != 1) begin
      n_bad++;
      $display("FAIL prescaled_latency: rose after tick %0d with %0d pulses, required tick 4 with 1",
               rose_at, pulses);
    end
  endtask

  task automatic test_irq_mask();
    settle();
    rise_en = 16'h0001; fall_en = 16'h0002;
    pin_in = 16'h0003;
    cyc(8);
    n_cmp++;
    if (irq_status !== 16'h0001 || irq !== 1'b1) begin
      n_bad++;
      $display("FAIL irq_mask_rise: status=%h irq=%b, required 0001/1", irq_status, irq);
    end
    pin_in = 16'h0000;
    cyc(8);
    n_cmp++;
    if (irq_status !== 16'h0003 || irq !== 1'b1) begin
      n_bad++;
      $display("FAIL irq_mask_fall: status=%h irq=%b, required 0003/1", irq_status, irq);
    end
  endtask

  task automatic test_set_beats_clear();
    bit found;
    settle();
    rise_en = 16'h0001;
    pin_in = 16'h0001;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      cyc(1);
      if (edge_rise[0]) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL set_clear_edge_timeout: edge_rise[0] seen=0, required 1 within 20 clk");
    end
    irq_clr_we = 1'b1; irq_clr = 16'h0001;
    cyc(1);
    irq_clr_we = 1'b0; irq_clr = '0;
    n_cmp++;
    if (irq_status[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL set_beats_clear: status0=%b, required 1", irq_status[0]);
    end
    cyc(2);
    irq_clr_we = 1'b1; irq_clr = 16'h0001;
    cyc(1);
    irq_clr_we = 1'b0; irq_clr = '0;
    n_cmp++;
    if (irq_status !== 16'h0000 || irq !== 1'b0) begin
      n_bad++;
      $display("FAIL later_clear: status=%h irq=%b, required 0000/0", irq_status, irq);
    end
  endtask

  task automatic test_reset_mid_count();
    settle();
    rise_en = 16'h0080;
    pin_in = 16'h0080;
    cyc(8);
    n_cmp++;
    if (irq_status !== 16'h0080) begin
      n_bad++;
      $display("FAIL mid_count_setup: status=%h, required 0080", irq_status);
    end
    pin_in = 16'h00A0;
    cyc(4);  // bit 5 counter has counted two ticks
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    n_cmp++;
    if (gpio_clean !== 16'h0000 || irq_status !== 16'h0000 || irq !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_count_reset: clean=%h status=%h irq=%b, required 0000/0000/0",
               gpio_clean, irq_status, irq);
    end
    for (int k = 1; k <= 6; k++) begin
      cyc(1);
      n_cmp++;
      if (gpio_clean !== ((k < 6) ? 16'h0000 : 16'h00A0)) begin
        n_bad++;
        $display("FAIL mid_count_reaccept edge %0d: clean=%h, required %h",
                 k, gpio_clean, (k < 6) ? 16'h0000 : 16'h00A0);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      rst         = ($urandom_range(0, 299) == 0);
      pin_in      = pin_in ^ W'($urandom & $urandom & $urandom);
      sample_tick = ($urandom_range(0, 3) != 0);
      if (c % 50 == 0) begin
        rise_en = W'($urandom);
        fall_en = W'($urandom);
      end
      irq_clr_we = ($urandom_range(0, 7) == 0);
      irq_clr    = W'($urandom);
      cyc(1);
      n_cmp++;
      if ({gpio_clean, edge_rise, edge_fall, irq_status, irq} !==
          {m_clean, m_rise, m_fall, m_status, |m_status}) begin
        n_bad++;
        $display("FAIL random cycle %0d: clean=%h rise=%h fall=%h status=%h irq=%b, required %h %h %h %h %b",
                 c, gpio_clean, edge_rise, edge_fall, irq_status, irq,
                 m_clean, m_rise, m_fall, m_status, |m_status);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_prescaled();
    test_irq_mask();
    test_set_beats_clear();
    test_reset_mid_count();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
